// File: rtl/acc_register_n.sv
// acc_register_n
// Parametrised accumulator for the SAP-BR datapath. Loads from the bus,
// drives the bus through a tristate output, always feeds the ULA, and
// executes single-cycle INC/DEC/CLR plus multi-cycle shift/rotate.
//
// States:
//   IDLE  | accepts bus loads and operation requests
//   SHIFT | performs one 1-bit shift/rotate step per edge; inputs ignored
//
// Ports:
//   CLOCK        in   system clock, rising edge
//   RESET        in   asynchronous active-low reset
//   ACC_IN       in   WIDTH-bit data from the bus
//   _EN_ACC_IN   in   active-low load strobe
//   _EN_ACC_OUT  in   active-low bus output enable
//   OP           in   operation code (NOP/INC/DEC/CLR/SHL/SHR/ROL/ROR)
//   OP_VALID     in   operation request
//   SHAMT        in   shift/rotate count
//   SERIAL_IN    in   fill bit for SHL/SHR
//   ACC_OUT      out  tristate bus output
//   ACC_OUT_ULA  out  register contents, always driven
//   BUSY         out  shift in progress
//   DONE         out  one-cycle completion pulse
//   ZERO/NEG     out  register == 0 / register MSB
//   CARRY        out  registered carry, borrow or shifted-out bit
module acc_register_n #(
    parameter int WIDTH   = 8,
    parameter int SHAMT_W = 3
) (
    input  logic               CLOCK,
    input  logic               RESET,
    input  logic [WIDTH-1:0]   ACC_IN,
    input  logic               _EN_ACC_IN,
    input  logic               _EN_ACC_OUT,
    input  logic [2:0]         OP,
    input  logic               OP_VALID,
    input  logic [SHAMT_W-1:0] SHAMT,
    input  logic               SERIAL_IN,
    output logic [WIDTH-1:0]   ACC_OUT,
    output logic [WIDTH-1:0]   ACC_OUT_ULA,
    output logic               BUSY,
    output logic               DONE,
    output logic               ZERO,
    output logic               NEG,
    output logic               CARRY
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam logic [2:0] OP_NOP = 3'b000;
    localparam logic [2:0] OP_INC = 3'b001;
    localparam logic [2:0] OP_DEC = 3'b010;
    localparam logic [2:0] OP_CLR = 3'b011;

    // Shift kind held in the low two opcode bits (OP[2] = 1 means shift).
    localparam logic [1:0] SK_SHL = 2'b00;
    localparam logic [1:0] SK_SHR = 2'b01;
    localparam logic [1:0] SK_ROL = 2'b10;
    localparam logic [1:0] SK_ROR = 2'b11;

    localparam logic [SHAMT_W-1:0] CNT_ZERO = '0;
    localparam logic [SHAMT_W-1:0] CNT_ONE  = SHAMT_W'(1);

    state_t             r_state, w_state_nxt;
    logic [WIDTH-1:0]   r_acc,   w_acc_nxt;
    logic               r_carry, w_carry_nxt;
    logic [SHAMT_W-1:0] r_cnt,   w_cnt_nxt;
    logic [1:0]         r_op,    w_op_nxt;
    logic               r_done,  w_done_nxt;

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            r_state <= IDLE;
            r_acc   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_op    <= SK_SHL;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_acc   <= w_acc_nxt;
            r_carry <= w_carry_nxt;
            r_cnt   <= w_cnt_nxt;
            r_op    <= w_op_nxt;
            r_done  <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_acc_nxt   = r_acc;
        w_carry_nxt = r_carry;
        w_cnt_nxt   = r_cnt;
        w_op_nxt    = r_op;
        w_done_nxt  = 1'b0;

        case (r_state)
            IDLE: begin
                // A bus load takes precedence and swallows any request.
                if (!_EN_ACC_IN) begin
                    w_acc_nxt = ACC_IN;
                end else if (OP_VALID) begin
                    case (OP)
                        OP_NOP: begin
                            w_done_nxt = 1'b1;
                        end
                        OP_INC: begin
                            w_acc_nxt   = r_acc + 1'b1;
                            w_carry_nxt = &r_acc;
                            w_done_nxt  = 1'b1;
                        end
                        OP_DEC: begin
                            w_acc_nxt   = r_acc - 1'b1;
                            w_carry_nxt = ~|r_acc;
                            w_done_nxt  = 1'b1;
                        end
                        OP_CLR: begin
                            w_acc_nxt   = '0;
                            w_carry_nxt = 1'b0;
                            w_done_nxt  = 1'b1;
                        end
                        default: begin
                            w_op_nxt  = OP[1:0];
                            w_cnt_nxt = SHAMT;
                            if (SHAMT == CNT_ZERO) begin
                                w_done_nxt = 1'b1;
                            end else begin
                                w_state_nxt = SHIFT;
                            end
                        end
                    endcase
                end
            end

            SHIFT: begin
                case (r_op)
                    SK_SHL: begin
                        w_carry_nxt = r_acc[WIDTH-1];
                        w_acc_nxt   = {r_acc[WIDTH-2:0], SERIAL_IN};
                    end
                    SK_SHR: begin
                        w_carry_nxt = r_acc[0];
                        w_acc_nxt   = {SERIAL_IN, r_acc[WIDTH-1:1]};
                    end
                    SK_ROL: begin
                        w_carry_nxt = r_acc[WIDTH-1];
                        w_acc_nxt   = {r_acc[WIDTH-2:0], r_acc[WIDTH-1]};
                    end
                    default: begin
                        w_carry_nxt = r_acc[0];
                        w_acc_nxt   = {r_acc[0], r_acc[WIDTH-1:1]};
                    end
                endcase

                // Terminal count: this edge performs the last step.
                if (r_cnt == CNT_ONE) begin
                    w_cnt_nxt   = CNT_ZERO;
                    w_state_nxt = IDLE;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign ACC_OUT     = _EN_ACC_OUT ? {WIDTH{1'bz}} : r_acc;
    assign ACC_OUT_ULA = r_acc;
    assign ZERO        = (r_acc == '0);
    assign NEG         = r_acc[WIDTH-1];
    assign CARRY       = r_carry;
    assign BUSY        = (r_state == SHIFT);
    assign DONE        = r_done;

endmodule
